// File: rtl/cpu_pkg.sv
// Shared decode constants: opcodes, ALU/write-back select codes and control-bundle bit positions.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned EX_W     = 5;
    localparam int unsigned MEM_W    = 5;
    localparam int unsigned JUMP_W   = 2;
    localparam int unsigned ALU_W    = 3;
    localparam int unsigned WBSEL_W  = 2;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_ST   = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_INC  = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_NEG  = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_J    = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_BRZ  = 4'b1001;
    localparam logic [OPCODE_W-1:0] OP_JM   = 4'b1010;
    localparam logic [OPCODE_W-1:0] OP_BRN  = 4'b1011;
    localparam logic [OPCODE_W-1:0] OP_LD   = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_SVPC = 4'b1111;

    localparam logic [ALU_W-1:0] ALU_PASS = 3'b000;
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_INC  = 3'b010;
    localparam logic [ALU_W-1:0] ALU_NEG  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'b100;

    localparam logic [WBSEL_W-1:0] WB_ALU    = 2'b00;
    localparam logic [WBSEL_W-1:0] WB_DMEM   = 2'b01;
    localparam logic [WBSEL_W-1:0] WB_TARGET = 2'b10;

    // ex_ctrl field positions
    localparam int unsigned EX_ALU_LSB   = 2;
    localparam int unsigned EX_MEM_WRITE = 1;
    localparam int unsigned EX_MEM_READ  = 0;

    // mem_ctrl field positions
    localparam int unsigned MEM_REG_WRITE = 4;
    localparam int unsigned MEM_WB_LSB    = 2;
    localparam int unsigned MEM_BRZ       = 1;
    localparam int unsigned MEM_BRN       = 0;

    // jump field positions
    localparam int unsigned JUMP_J  = 1;
    localparam int unsigned JUMP_JM = 0;

endpackage

// File: rtl/decode_branch_unit_if.sv
// Decode-stage bus: IF/ID and write-back inputs toward the unit, control bundles and PC values back.
interface decode_branch_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
);
    logic [OPW-1:0]   opcode;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] imm;
    logic             wb_brz;
    logic             wb_brn;
    logic             wb_jump;
    logic             z;
    logic             n;
    logic [4:0]       ex_ctrl;
    logic [4:0]       mem_ctrl;
    logic [1:0]       jump;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc_plus1;
    logic             take;

    modport master (
        output opcode, pc, imm, wb_brz, wb_brn, wb_jump, z, n,
        input  ex_ctrl, mem_ctrl, jump, target, pc_plus1, take
    );

    modport slave (
        input  opcode, pc, imm, wb_brz, wb_brn, wb_jump, z, n,
        output ex_ctrl, mem_ctrl, jump, target, pc_plus1, take
    );
endinterface

// File: rtl/wrap_adder.sv
// Modulo-2^WIDTH adder; carry out is intentionally discarded.
module wrap_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/decode_branch_unit.sv
// Decode-stage control: opcode -> registered EX/MEM/jump bundles, PC+1 / PC+imm adders,
// and the write-back branch-taken select for the PC mux.
module decode_branch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    decode_branch_unit_if.slave  bus
);

    logic [OPW-1:0]    opcode;
    logic [EX_W-1:0]   ex_d;
    logic [MEM_W-1:0]  mem_d;
    logic [JUMP_W-1:0] jump_d;
    logic [WIDTH-1:0]  target_d;
    logic [WIDTH-1:0]  pc_plus1;

    assign opcode = bus.opcode;

    wrap_adder #(.WIDTH(WIDTH)) u_inc (
        .a   (bus.pc),
        .b   (WIDTH'(1)),
        .sum (pc_plus1)
    );

    wrap_adder #(.WIDTH(WIDTH)) u_target (
        .a   (bus.pc),
        .b   (bus.imm),
        .sum (target_d)
    );

    assign bus.pc_plus1 = pc_plus1;

    // Redirect when the write-back instruction's branch condition holds.
    assign bus.take = (bus.wb_brz & bus.z) | (bus.wb_brn & bus.n) | bus.wb_jump;

    // Opcode decode; anything not listed falls through to the all-zero NOP bundle.
    always_comb begin
        ex_d   = '0;
        mem_d  = '0;
        jump_d = '0;
        case (opcode)
            OP_NOP: ;
            OP_SVPC: begin
                mem_d[MEM_REG_WRITE]               = 1'b1;
                mem_d[MEM_WB_LSB +: WBSEL_W]       = WB_TARGET;
            end
            OP_LD: begin
                ex_d[EX_MEM_READ]                  = 1'b1;
                mem_d[MEM_REG_WRITE]               = 1'b1;
                mem_d[MEM_WB_LSB +: WBSEL_W]       = WB_DMEM;
            end
            OP_ST:  ex_d[EX_MEM_WRITE] = 1'b1;
            OP_ADD, OP_INC, OP_NEG, OP_SUB: begin
                mem_d[MEM_REG_WRITE]               = 1'b1;
                mem_d[MEM_WB_LSB +: WBSEL_W]       = WB_ALU;
                case (opcode)
                    OP_ADD:  ex_d[EX_ALU_LSB +: ALU_W] = ALU_ADD;
                    OP_INC:  ex_d[EX_ALU_LSB +: ALU_W] = ALU_INC;
                    OP_NEG:  ex_d[EX_ALU_LSB +: ALU_W] = ALU_NEG;
                    default: ex_d[EX_ALU_LSB +: ALU_W] = ALU_SUB;
                endcase
            end
            OP_J: begin
                ex_d[EX_ALU_LSB +: ALU_W]          = ALU_PASS;
                jump_d[JUMP_J]                     = 1'b1;
            end
            OP_JM: begin
                ex_d[EX_MEM_READ]                  = 1'b1;
                jump_d[JUMP_JM]                    = 1'b1;
            end
            OP_BRZ: begin
                ex_d[EX_ALU_LSB +: ALU_W]          = ALU_PASS;
                mem_d[MEM_BRZ]                     = 1'b1;
            end
            OP_BRN: begin
                ex_d[EX_ALU_LSB +: ALU_W]          = ALU_PASS;
                mem_d[MEM_BRN]                     = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset flushes the in-flight bundle to NOP ahead of this cycle's capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.ex_ctrl  <= '0;
            bus.mem_ctrl <= '0;
            bus.jump     <= '0;
            bus.target   <= '0;
        end else begin
            bus.ex_ctrl  <= ex_d;
            bus.mem_ctrl <= mem_d;
            bus.jump     <= jump_d;
            bus.target   <= target_d;
        end
    end

endmodule

// File: tb/tb_decode_branch_unit.sv
// Directed bench for decode_branch_unit: reset, opcode sweep, adders, branch select, mid-stream reset.
module tb_decode_branch_unit;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fails;

    decode_branch_unit_if #(.WIDTH(32), .OPW(4)) bus ();

    decode_branch_unit #(.WIDTH(32), .OPW(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hand-derived {ex_ctrl, mem_ctrl, jump} per opcode 0..15.
    logic [11:0] exp_tab [16];
    initial begin
        exp_tab[0]  = {5'b00000, 5'b00000, 2'b00};
        exp_tab[1]  = {5'b00000, 5'b00000, 2'b00};
        exp_tab[2]  = {5'b00000, 5'b00000, 2'b00};
        exp_tab[3]  = {5'b00010, 5'b00000, 2'b00};
        exp_tab[4]  = {5'b00100, 5'b10000, 2'b00};
        exp_tab[5]  = {5'b01000, 5'b10000, 2'b00};
        exp_tab[6]  = {5'b01100, 5'b10000, 2'b00};
        exp_tab[7]  = {5'b10000, 5'b10000, 2'b00};
        exp_tab[8]  = {5'b00000, 5'b00000, 2'b10};
        exp_tab[9]  = {5'b00000, 5'b00010, 2'b00};
        exp_tab[10] = {5'b00001, 5'b00000, 2'b01};
        exp_tab[11] = {5'b00000, 5'b00001, 2'b00};
        exp_tab[12] = {5'b00000, 5'b00000, 2'b00};
        exp_tab[13] = {5'b00000, 5'b00000, 2'b00};
        exp_tab[14] = {5'b00001, 5'b10100, 2'b00};
        exp_tab[15] = {5'b00000, 5'b11000, 2'b00};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_br(input logic brz, input logic brn, input logic jmp,
                          input logic zf, input logic nf);
        bus.wb_brz  = brz;
        bus.wb_brn  = brn;
        bus.wb_jump = jmp;
        bus.z       = zf;
        bus.n       = nf;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset       = 1'b1;
        bus.opcode  = 4'b0100;
        bus.pc      = 32'h20;
        bus.imm     = 32'h4;
        bus.wb_brz  = 1'b0;
        bus.wb_brn  = 1'b0;
        bus.wb_jump = 1'b0;
        bus.z       = 1'b0;
        bus.n       = 1'b0;

        // Reset dominates an ADD presented on the same edge
        tick();
        chk("rst_ex",       32'(bus.ex_ctrl),  32'h0);
        chk("rst_mem",      32'(bus.mem_ctrl), 32'h0);
        chk("rst_jump",     32'(bus.jump),     32'h0);
        chk("rst_target",   bus.target,        32'h0);
        chk("rst_pc_plus1", bus.pc_plus1,      32'h21);
        chk("rst_take",     32'(bus.take),     32'h0);

        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [11:0] e;
            bus.opcode = 4'(i);
            bus.pc     = 32'(i * 16);
            bus.imm    = 32'(i);
            tick();
            e = exp_tab[i];
            chk($sformatf("ex_op%0d", i),     32'(bus.ex_ctrl),  32'(e[11:7]));
            chk($sformatf("mem_op%0d", i),    32'(bus.mem_ctrl), 32'(e[6:2]));
            chk($sformatf("jump_op%0d", i),   32'(bus.jump),     32'(e[1:0]));
            chk($sformatf("target_op%0d", i), bus.target,        32'(i * 17));
        end

        // Negative immediate and PC wrap
        bus.opcode = 4'b0000;
        bus.pc     = 32'h10;
        bus.imm    = 32'hFFFF_FFFC;
        #1;
        chk("pc_plus1_0x10", bus.pc_plus1, 32'h11);
        tick();
        chk("target_neg_imm", bus.target, 32'h0C);
        bus.pc  = 32'hFFFF_FFFF;
        bus.imm = 32'h1;
        #1;
        chk("pc_plus1_wrap", bus.pc_plus1, 32'h0);
        tick();
        chk("target_wrap", bus.target, 32'h0);
        bus.pc  = 32'h100;
        bus.imm = 32'hFFFF_FFFF;
        tick();
        chk("target_minus1", bus.target, 32'hFF);

        // Branch select: {brz, brn, jump, z, n}
        set_br(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); chk("take_brz_z",     32'(bus.take), 32'h1);
        set_br(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); chk("take_brz_nz",    32'(bus.take), 32'h0);
        set_br(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); chk("take_brn_n",     32'(bus.take), 32'h1);
        set_br(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); chk("take_jump",      32'(bus.take), 32'h1);
        set_br(1'b1, 1'b1, 1'b0, 1'b1, 1'b1); chk("take_both",      32'(bus.take), 32'h1);
        set_br(1'b0, 1'b0, 1'b0, 1'b1, 1'b1); chk("take_flags_only",32'(bus.take), 32'h0);
        set_br(1'b0, 1'b1, 1'b0, 1'b1, 1'b0); chk("take_brn_z",     32'(bus.take), 32'h0);
        set_br(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Mid-stream reset flushes a captured SVPC, then decoding resumes
        bus.opcode = 4'b1111;
        bus.pc     = 32'h40;
        bus.imm    = 32'h8;
        tick();
        chk("mid_svpc_mem",    32'(bus.mem_ctrl), 32'h18);
        chk("mid_svpc_target", bus.target,        32'h48);
        reset = 1'b1;
        tick();
        chk("mid_rst_mem",    32'(bus.mem_ctrl), 32'h0);
        chk("mid_rst_target", bus.target,        32'h0);
        reset      = 1'b0;
        bus.opcode = 4'b0100;
        tick();
        chk("resume_ex",  32'(bus.ex_ctrl),  32'h04);
        chk("resume_mem", 32'(bus.mem_ctrl), 32'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
